// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, reset PC and FIFO entry layout.
package ifu_pkg;

   localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fsm_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, inst} pairs with flush; head is read combinationally.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  ifu_entry_t    push_data,
   input  logic          pop,
   input  logic          flush,
   output ifu_entry_t    head,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   ifu_entry_t    mem [DEPTH];
   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign count   = count_reg;
   assign do_pop  = pop && !empty && !flush;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop) && !flush;
   assign head    = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the fetch PC, keeps one imem read outstanding and buffers words for the core.
// Define IFU_PERF_EN to add the fetch/stall performance counters.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef IFU_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fsm_t          state_reg;
   logic [31:0]   fetch_pc_reg;
   logic [31:0]   req_pc_reg;
   ifu_entry_t    head;
   ifu_entry_t    push_entry;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] count_after;
   logic          push;
   logic          pop;

   // A redirect discards both the buffered words and any response landing in that cycle.
   assign pop         = inst_ready && !fifo_empty && !redirect_valid;
   assign push        = (state_reg == WAIT) && imem_resp_valid && !redirect_valid;
   assign push_entry  = '{pc: req_pc_reg, inst: imem_resp_data};
   assign count_after = fifo_count + CW'(1) - CW'(pop);

   ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign imem_req_valid = (state_reg == REQ);
   assign imem_req_addr  = fetch_pc_reg;
   assign inst_valid     = !fifo_empty;
   assign inst           = head.inst;
   assign inst_pc        = head.pc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         req_pc_reg   <= RESET_PC;
      end else if (redirect_valid) begin
         fetch_pc_reg <= redirect_pc & 32'hFFFF_FFFC;
         case (state_reg)
            WAIT:    state_reg <= imem_resp_valid ? REQ : DROP;
            REQ:     state_reg <= imem_req_ready ? DROP : REQ;
            DROP:    state_reg <= imem_resp_valid ? REQ : DROP;
            default: state_reg <= REQ;
         endcase
      end else begin
         case (state_reg)
            IDLE: if (!fifo_full) state_reg <= REQ;
            REQ: begin
               if (imem_req_ready) begin
                  req_pc_reg   <= fetch_pc_reg;
                  fetch_pc_reg <= fetch_pc_reg + 32'd4;
                  state_reg    <= WAIT;
               end
            end
            WAIT: begin
               if (imem_resp_valid)
                  state_reg <= (count_after < CW'(DEPTH)) ? REQ : IDLE;
            end
            DROP: if (imem_resp_valid) state_reg <= REQ;
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef IFU_PERF_EN
   logic [31:0] fetch_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_reg <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (push) fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
         if (inst_ready && fifo_empty && !redirect_valid) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_reg;
   assign perf_stall_cnt = stall_cnt_reg;
`endif

endmodule
